// File: rtl/dvi_timing_pkg.sv
// Shared constants for the DVI raster timing generator: video modes,
// FSM encoding and colour-bar palette.
package dvi_timing_pkg;

    localparam int M720_H_ACTIVE = 1280;
    localparam int M720_H_FP     = 110;
    localparam int M720_H_SYNC   = 40;
    localparam int M720_H_BP     = 220;
    localparam int M720_V_ACTIVE = 720;
    localparam int M720_V_FP     = 5;
    localparam int M720_V_SYNC   = 5;
    localparam int M720_V_BP     = 20;
    localparam logic M720_HS_POL = 1'b1;
    localparam logic M720_VS_POL = 1'b1;

    localparam int M480_H_ACTIVE = 640;
    localparam int M480_H_FP     = 16;
    localparam int M480_H_SYNC   = 96;
    localparam int M480_H_BP     = 48;
    localparam int M480_V_ACTIVE = 480;
    localparam int M480_V_FP     = 10;
    localparam int M480_V_SYNC   = 2;
    localparam int M480_V_BP     = 33;
    localparam logic M480_HS_POL = 1'b0;
    localparam logic M480_VS_POL = 1'b0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] c;
        c = RGB_BLACK;
        case (idx)
            3'd0: c = RGB_WHITE;
            3'd1: c = RGB_YELLOW;
            3'd2: c = RGB_CYAN;
            3'd3: c = RGB_GREEN;
            3'd4: c = RGB_MAGENTA;
            3'd5: c = RGB_RED;
            3'd6: c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvi_timing_axis.sv
// One raster axis: position counter with wrap, plus active and sync
// region flags decoded from the current count.
module dvi_timing_axis
    import dvi_timing_pkg::*;
#(
    parameter int ACTIVE = 1280,
    parameter int FP     = 110,
    parameter int SYNC   = 40,
    parameter int BP     = 220,
    parameter int W      = 12
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_count,
    output logic         o_wrap,
    output logic         o_active,
    output logic         o_sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [W:0] LAST     = (W+1)'(TOTAL - 1);
    localparam logic [W:0] ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);

    logic [W:0] cnt_x;

    assign cnt_x    = {1'b0, o_count};
    assign o_wrap   = (cnt_x == LAST);
    assign o_active = (cnt_x < ACT_END);
    assign o_sync   = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_en) begin
            o_count <= o_wrap ? '0 : o_count + 1'b1;
        end
    end

endmodule

// File: rtl/dvi_video_timing_gen.sv
// Raster timing generator (IDLE/RUN) with registered sync/DE/coords.
// Define DVI_TEST_PATTERN_EN to add the o_rgb colour-bar output.
module dvi_video_timing_gen
    import dvi_timing_pkg::*;
#(
    parameter int   H_ACTIVE = M720_H_ACTIVE,
    parameter int   H_FP     = M720_H_FP,
    parameter int   H_SYNC   = M720_H_SYNC,
    parameter int   H_BP     = M720_H_BP,
    parameter int   V_ACTIVE = M720_V_ACTIVE,
    parameter int   V_FP     = M720_V_FP,
    parameter int   V_SYNC   = M720_V_SYNC,
    parameter int   V_BP     = M720_V_BP,
    parameter logic HS_POL   = M720_HS_POL,
    parameter logic VS_POL   = M720_VS_POL,
    parameter int   XY_W     = 12
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic            i_enable,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_de,
    output logic [XY_W-1:0] o_x,
    output logic [XY_W-1:0] o_y,
    output logic            o_line_start,
    output logic            o_frame_start
`ifdef DVI_TEST_PATTERN_EN
    ,
    output logic [23:0]     o_rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $fatal(1, "dvi_video_timing_gen: porch/sync width of 0");
    end
    if (H_TOTAL > 2**XY_W || V_TOTAL > 2**XY_W) begin : g_bad_width
        $fatal(1, "dvi_video_timing_gen: total exceeds XY_W");
    end

    logic [0:0]      state;
    logic            run;
    logic            cnt_en;
    logic [XY_W-1:0] h;
    logic [XY_W-1:0] v;
    logic            h_wrap, h_act, h_sync;
    logic            v_wrap, v_act, v_sync;

    assign run    = (state == ST_RUN);
    assign cnt_en = run && i_enable;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= i_enable ? ST_RUN : ST_IDLE;
        end
    end

    // Counters clear whenever not counting, so any (re)start is at (0,0).
    dvi_timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (XY_W)
    ) u_h_axis (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_en     (cnt_en),
        .i_clr    (!cnt_en),
        .o_count  (h),
        .o_wrap   (h_wrap),
        .o_active (h_act),
        .o_sync   (h_sync)
    );

    dvi_timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (XY_W)
    ) u_v_axis (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_en     (cnt_en && h_wrap),
        .i_clr    (!cnt_en),
        .o_count  (v),
        .o_wrap   (v_wrap),
        .o_active (v_act),
        .o_sync   (v_sync)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (run) begin
            o_hsync       <= h_sync ? HS_POL : ~HS_POL;
            o_vsync       <= v_sync ? VS_POL : ~VS_POL;
            o_de          <= h_act && v_act;
            o_x           <= h;
            o_y           <= v;
            o_line_start  <= (h == '0);
            o_frame_start <= (h == '0) && (v == '0);
        end else begin
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end
    end

`ifdef DVI_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    if (BAR_W == 0) begin : g_bad_bar
        $fatal(1, "dvi_video_timing_gen: H_ACTIVE too small for bars");
    end

    logic [23:0] bar_c;
    logic [XY_W-1:0] bar_q;

    assign bar_q = h / XY_W'(BAR_W);

    // Trailing pixels past the last whole bar stay black.
    always_comb begin
        bar_c = RGB_BLACK;
        if (h < XY_W'(8 * BAR_W)) begin
            bar_c = bar_rgb(bar_q[2:0]);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_rgb <= '0;
        end else if (run && h_act && v_act) begin
            o_rgb <= bar_c;
        end else begin
            o_rgb <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_dvi_video_timing_gen.sv
// Scoreboard bench for dvi_video_timing_gen on a reduced raster.
// Define DVI_TEST_PATTERN_EN to also check the colour bars.
module tb_dvi_video_timing_gen;

`ifdef DVI_TEST_PATTERN_EN
    localparam int HA = 16;
`else
    localparam int HA = 8;
`endif
    localparam int HF   = 2;
    localparam int H_SY = 3;
    localparam int HB   = 2;
    localparam int VA   = 4;
    localparam int VF   = 1;
    localparam int V_SY = 2;
    localparam int VB   = 1;
    localparam int HT   = HA + HF + H_SY + HB;
    localparam int VT   = VA + VF + V_SY + VB;
    localparam logic HSP = 1'b1;
    localparam logic VSP = 1'b1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] rgb;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        o_hsync, o_vsync, o_de;
    logic [11:0] o_x, o_y;
    logic        o_line_start, o_frame_start;
    logic [23:0] rgb_w;
    out_t        obs;

    out_t q[$];
    int   checks;
    int   errors;
    logic mrun;
    int   mh, mv;

    dvi_video_timing_gen #(
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (H_SY),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (V_SY),
        .V_BP     (VB),
        .HS_POL   (HSP),
        .VS_POL   (VSP),
        .XY_W     (12)
    ) dut (
        .i_clk         (clk),
        .i_arst_n      (rst_n),
        .i_enable      (en),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_de          (o_de),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_line_start  (o_line_start),
        .o_frame_start (o_frame_start)
`ifdef DVI_TEST_PATTERN_EN
        ,
        .o_rgb         (rgb_w)
`endif
    );

`ifndef DVI_TEST_PATTERN_EN
    assign rgb_w = 24'h0;
`endif

    assign obs = {o_hsync, o_vsync, o_de, o_line_start, o_frame_start,
                  o_x, o_y, rgb_w};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] exp_bar(input int x);
        int bw;
        bw = HA / 8;
        if (x >= 8 * bw) return 24'h000000;
        case (x / bw)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic out_t reset_out();
        out_t r;
        r    = '0;
        r.hs = ~HSP;
        r.vs = ~VSP;
        return r;
    endfunction

    function automatic out_t model_out();
        out_t r;
        r = reset_out();
        if (mrun) begin
            r.de = (mh < HA) && (mv < VA);
            r.hs = (mh >= HA + HF && mh < HA + HF + H_SY) ? HSP : ~HSP;
            r.vs = (mv >= VA + VF && mv < VA + VF + V_SY) ? VSP : ~VSP;
            r.ls = (mh == 0);
            r.fs = (mh == 0) && (mv == 0);
            r.x  = 12'(mh);
            r.y  = 12'(mv);
`ifdef DVI_TEST_PATTERN_EN
            if (r.de) r.rgb = exp_bar(mh);
`endif
        end
        return r;
    endfunction

    task automatic model_adv();
        if (mrun && en) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            mh = 0;
            mv = 0;
        end
        mrun = en;
    endtask

    task automatic checkv(input string tag, input logic [63:0] o,
                          input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        out_t e;
        q.push_back(model_out());
        model_adv();
        @(posedge clk);
        #1;
        e = q.pop_front();
        checkv("cycle", 64'(obs), 64'(e));
    endtask

    initial begin
        int pulses;
        int lastfs;
        checks = 0;
        errors = 0;
        mrun   = 1'b0;
        mh     = 0;
        mv     = 0;
        rst_n  = 1'b0;
        en     = 1'b0;

        #3;
        checkv("reset", 64'(obs), 64'(reset_out()));
        #10;
        rst_n = 1'b1;

        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (o_line_start || o_frame_start) pulses++;
        end
        checkv("idle_pulses", 64'(pulses), 64'd0);

        en = 1'b1;
        step();
        step();
        checkv("start_fs", 64'(o_frame_start), 64'd1);
        checkv("start_xy", 64'({o_x, o_y, o_de}), 64'({24'd0, 1'b1}));

        pulses = 0;
        lastfs = 0;
        for (int n = 1; n <= 3 * HT * VT; n++) begin
            step();
            if (o_line_start) pulses++;
            if (o_frame_start) begin
                checkv("fs_gap", 64'(n - lastfs), 64'(HT * VT));
                lastfs = n;
            end
        end
        checkv("ls_count", 64'(pulses), 64'(3 * VT));

        for (int i = 0; i < HT * VT + 2; i++) begin
            if (o_x == 12'(HA + HF + 1) && o_y == 12'(VA + VF)) break;
            step();
        end
        checkv("drop_pos", 64'({o_x, o_y}),
               64'({12'(HA + HF + 1), 12'(VA + VF)}));
        checkv("drop_sync", 64'({o_hsync, o_vsync}), 64'({HSP, VSP}));
        en = 1'b0;
        step();
        step();
        checkv("drop_idle", 64'(obs), 64'(reset_out()));
        for (int i = 0; i < 5; i++) step();
        en = 1'b1;
        step();
        step();
        checkv("restart_fs", 64'({o_frame_start, o_x, o_y}), 64'({1'b1, 24'd0}));

        for (int i = 0; i < HT * VT + 2; i++) begin
            if (o_x == 12'd3 && o_y != 12'd0) break;
            step();
        end
        checkv("rst_pos", 64'(o_x), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        checkv("async_rst", 64'(obs), 64'(reset_out()));
        mrun = 1'b0;
        mh   = 0;
        mv   = 0;
        @(posedge clk);
        #1;
        checkv("rst_hold", 64'(obs), 64'(reset_out()));
        #3;
        rst_n = 1'b1;
        step();
        step();
        checkv("rst_restart", 64'({o_frame_start, o_x, o_y}), 64'({1'b1, 24'd0}));
        for (int i = 0; i < HT * VT; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
